// File: rtl/seg7_pkg.sv
// Shared constants, scan FSM states and the 7-segment decoder
// for the serial 6-digit display driver.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int MAX_VALUE  = 999999;
  localparam int BIN_W      = 20;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    LATCH_END
  } scan_state_e;

  // Active-low {a,b,c,d,e,f,g,dp}
  function automatic logic [7:0] decode7seg(input logic [3:0] dig);
    logic [7:0] seg;
    case (dig)
      4'd0:    seg = 8'h03;
      4'd1:    seg = 8'h9F;
      4'd2:    seg = 8'h25;
      4'd3:    seg = 8'h0D;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h49;
      4'd6:    seg = 8'h41;
      4'd7:    seg = 8'h1F;
      4'd8:    seg = 8'h01;
      4'd9:    seg = 8'h09;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential double-dabble: start loads bin, 20 shifts follow,
// done pulses one cycle after the last shift with bcd stable.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       acc_q, acc_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] sh;

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    sh = {adj, bin_q} << 1;
  end

  always_comb begin
    bin_d  = bin_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      bin_d  = bin;
      acc_d  = '0;
      cnt_d  = 5'(BIN_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = sh[BCD_W+BIN_W-1:BIN_W];
      bin_d = sh[BIN_W-1:0];
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = acc_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// 6-digit display driver: binary capture -> BCD, then serial scan
// into segment/common 74HC595 chains (ser, srclk, rclk, oe_n).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter bit LEAD_BLANK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [BIN_W-1:0] value,
  input  logic             value_valid,
  output logic             value_ready,
  output logic             seg_ser,
  output logic             com_ser,
  output logic             srclk,
  output logic             seg_rclk,
  output logic             com_rclk,
  output logic             seg_oe_n,
  output logic             com_oe_n
);

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VALUE);

  logic             capture;
  logic [BIN_W-1:0] bin_clamped;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  logic             ready_q, ready_d;
  logic [BCD_W-1:0] digits_q, digits_d;

  scan_state_e state_q, state_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  d_q, d_d;
  logic [7:0]  seg_byte_q, seg_byte_d;
  logic [7:0]  com_byte_q, com_byte_d;
  logic        seg_ser_q, seg_ser_d;
  logic        com_ser_q, com_ser_d;
  logic        srclk_q, srclk_d;
  logic        rclk_q, rclk_d;
  logic        oe_n_q, oe_n_d;

  logic [3:0]  dig;
  logic        blank;
  logic        nz;
  logic [7:0]  frame_seg;
  logic [7:0]  frame_com;

  assign capture     = value_valid & ready_q;
  assign bin_clamped = (value > MAX_BIN) ? MAX_BIN : value;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (capture),
    .bin   (bin_clamped),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    ready_d  = ready_q;
    digits_d = digits_q;
    if (capture) begin
      ready_d = 1'b0;
    end else if (conv_done) begin
      ready_d  = 1'b1;
      digits_d = conv_bcd;
    end
  end

  // Walk from the top digit down so nz tells whether anything
  // at or above the selected position is non-zero.
  always_comb begin
    dig       = 4'd0;
    blank     = 1'b0;
    nz        = 1'b0;
    frame_com = 8'hFF;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (digits_q[4*k +: 4] != 4'd0)
        nz = 1'b1;
      if (d_q == 3'(k)) begin
        dig          = digits_q[4*k +: 4];
        blank        = LEAD_BLANK && !nz && (k != 0);
        frame_com[k] = 1'b0;
      end
    end
    frame_seg = blank ? SEG_BLANK : decode7seg(dig);
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        IDLE:      state_d = SHIFT_LO;
        SHIFT_LO:  state_d = SHIFT_HI;
        SHIFT_HI:  state_d = (n_q == 3'd7) ? LATCH : SHIFT_LO;
        LATCH:     state_d = LATCH_END;
        LATCH_END: state_d = SHIFT_LO;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Frame bytes are frozen on entry to the first SHIFT_LO so a
  // digit update arriving mid-frame cannot tear the shifted byte.
  always_comb begin
    n_d        = n_q;
    d_d        = d_q;
    seg_byte_d = seg_byte_q;
    com_byte_d = com_byte_q;
    seg_ser_d  = seg_ser_q;
    com_ser_d  = com_ser_q;
    srclk_d    = srclk_q;
    rclk_d     = rclk_q;
    oe_n_d     = oe_n_q;
    if (tick) begin
      unique case (state_q)
        IDLE, LATCH_END: begin
          seg_byte_d = frame_seg;
          com_byte_d = frame_com;
          seg_ser_d  = frame_seg[7];
          com_ser_d  = frame_com[7];
          srclk_d    = 1'b0;
          n_d        = 3'd0;
        end
        SHIFT_LO: begin
          srclk_d = 1'b1;
        end
        SHIFT_HI: begin
          n_d = n_q + 3'd1;
          if (n_q == 3'd7) begin
            rclk_d = 1'b1;
          end else begin
            srclk_d   = 1'b0;
            seg_ser_d = seg_byte_q[3'd6 - n_q];
            com_ser_d = com_byte_q[3'd6 - n_q];
          end
        end
        LATCH: begin
          rclk_d = 1'b0;
          oe_n_d = 1'b0;
          d_d    = (d_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : d_q + 3'd1;
        end
        default: begin
          srclk_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      d_q        <= '0;
      ready_q    <= 1'b1;
      digits_q   <= '0;
      seg_byte_q <= 8'hFF;
      com_byte_q <= 8'hFF;
      seg_ser_q  <= 1'b1;
      com_ser_q  <= 1'b1;
      srclk_q    <= 1'b0;
      rclk_q     <= 1'b0;
      oe_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      d_q        <= d_d;
      ready_q    <= ready_d;
      digits_q   <= digits_d;
      seg_byte_q <= seg_byte_d;
      com_byte_q <= com_byte_d;
      seg_ser_q  <= seg_ser_d;
      com_ser_q  <= com_ser_d;
      srclk_q    <= srclk_d;
      rclk_q     <= rclk_d;
      oe_n_q     <= oe_n_d;
    end
  end

  assign value_ready = ready_q;
  assign seg_ser     = seg_ser_q;
  assign com_ser     = com_ser_q;
  assign srclk       = srclk_q;
  assign seg_rclk    = rclk_q;
  assign com_rclk    = rclk_q;
  assign seg_oe_n    = oe_n_q;
  assign com_oe_n    = oe_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: models both 595 chains
// from the serial pins and checks latched bytes per digit.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [19:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic        seg_ser, com_ser, srclk;
  logic        seg_rclk, com_rclk;
  logic        seg_oe_n, com_oe_n;

  int checks = 0;
  int fails = 0;

  logic [7:0] seg_sr = 8'h00;
  logic [7:0] com_sr = 8'h00;
  logic [7:0] seg_lat = 8'h00;
  logic [7:0] com_lat = 8'h00;
  logic       prev_srclk = 1'b0;
  logic       prev_rclk = 1'b0;
  int         bit_cnt = 0;
  int         latch_cnt = 0;

  bit tick_en = 1'b0;
  int tick_div = 1;
  int tick_cnt = 0;

  logic [7:0] scan_seg[6];
  bit         scan_got[6];

  localparam logic [7:0] RST_VEC = 8'b1110_0011;

  seg7_scan_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .seg_ser     (seg_ser),
    .com_ser     (com_ser),
    .srclk       (srclk),
    .seg_rclk    (seg_rclk),
    .com_rclk    (com_rclk),
    .seg_oe_n    (seg_oe_n),
    .com_oe_n    (com_oe_n)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    if (tick_en) begin
      tick_cnt = (tick_cnt + 1) % tick_div;
      tick = (tick_cnt == 0);
    end else begin
      tick = 1'b0;
    end
  end

  // Behavioural model of the two 595 chains
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bit_cnt = 0;
    end else begin
      if (srclk && !prev_srclk) begin
        seg_sr = {seg_sr[6:0], seg_ser};
        com_sr = {com_sr[6:0], com_ser};
        bit_cnt++;
      end
      if (seg_rclk && !prev_rclk) begin
        seg_lat = seg_sr;
        com_lat = com_sr;
        latch_cnt++;
        bit_cnt = 0;
      end
    end
    prev_srclk = srclk;
    prev_rclk = seg_rclk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] out_vec();
    return {value_ready, seg_ser, com_ser, srclk,
            seg_rclk, com_rclk, seg_oe_n, com_oe_n};
  endfunction

  task automatic wait_latch(output bit ok);
    int start;
    start = latch_cnt;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (latch_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bits(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (bit_cnt == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic collect_scan(output bit ok);
    bit         lok;
    logic [7:0] m;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) scan_got[i] = 1'b0;
    for (int f = 0; f < 6; f++) begin
      wait_latch(lok);
      if (!lok) ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
        m = 8'h01 << i;
        m = ~m;
        if (com_lat == m) begin
          scan_seg[i] = seg_lat;
          scan_got[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic do_capture(input logic [19:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (value_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      value = v;
      value_valid = 1'b1;
      @(posedge clk);
      #2;
      value_valid = 1'b0;
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (value_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_scan(input string name, input logic [47:0] exp);
    bit ok;
    collect_scan(ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: latch count short, got %0d", name, latch_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!scan_got[i] || scan_seg[i] !== exp[8*i +: 8]) begin
        fails++;
        $display("FAIL %s_d%0d: seg got %h (seen %0d) expected %h",
                 name, i, scan_seg[i], scan_got[i], exp[8*i +: 8]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick_en = 1'b0;
    value_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (out_vec() !== RST_VEC) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b", out_vec(), RST_VEC);
    end
  endtask

  task automatic test_first_frame();
    int         lc0;
    logic       es;
    logic [1:0] er, eo;
    tick_div = 1;
    tick_en = 1'b1;
    @(posedge clk);
    #2;
    lc0 = latch_cnt;
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #2;
      er = (k == 17) ? 2'b11 : 2'b00;
      eo = (k >= 18) ? 2'b00 : 2'b11;
      checks++;
      if ({seg_rclk, com_rclk} !== er) begin
        fails++;
        $display("FAIL first_rclk_t%0d: got %b expected %b", k, {seg_rclk, com_rclk}, er);
      end
      checks++;
      if ({seg_oe_n, com_oe_n} !== eo) begin
        fails++;
        $display("FAIL first_oe_t%0d: got %b expected %b", k, {seg_oe_n, com_oe_n}, eo);
      end
      if (k <= 16) begin
        es = (k % 2 == 0);
        checks++;
        if (srclk !== es) begin
          fails++;
          $display("FAIL first_srclk_t%0d: got %b expected %b", k, srclk, es);
        end
      end
    end
    checks++;
    if (latch_cnt != lc0 + 1 || seg_lat !== 8'h03 || com_lat !== 8'hFE) begin
      fails++;
      $display("FAIL first_frame: latches %0d seg %h com %h expected 1 03 FE",
               latch_cnt - lc0, seg_lat, com_lat);
    end
    check_scan("zero_scan", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03});
  endtask

  task automatic test_capture_123456();
    bit ok;
    do_capture(20'd123456, ok);
    checks++;
    if (!ok || value_ready !== 1'b0) begin
      fails++;
      $display("FAIL cap_ready_drop: ok %0d ready %b expected 1 0", ok, value_ready);
    end
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk);
      #2;
      if (i == 20) begin
        checks++;
        if (value_ready !== 1'b0) begin
          fails++;
          $display("FAIL cap_ready_c20: got %b expected 0", value_ready);
        end
      end
      if (i == 21) begin
        checks++;
        if (value_ready !== 1'b1) begin
          fails++;
          $display("FAIL cap_ready_c21: got %b expected 1", value_ready);
        end
      end
    end
    wait_latch(ok);
    check_scan("v123456", {8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41});
  endtask

  task automatic test_clamp();
    bit ok;
    do_capture(20'hFFFFF, ok);
    wait_ready(ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL clamp_ready: got 0 expected 1");
    end
    wait_latch(ok);
    check_scan("clamp", {6{8'h09}});
  endtask

  task automatic test_lead_blank();
    bit ok;
    do_capture(20'd42, ok);
    wait_ready(ok);
    wait_latch(ok);
    check_scan("blank42", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'h25});
  endtask

  task automatic test_mid_frame();
    bit ok;
    tick_div = 4;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit lok;
      wait_latch(lok);
      if (com_lat == 8'hFD) begin
        ok = 1'b1;
        break;
      end
    end
    wait_bits(4, ok);
    do_capture(20'd987654, ok);
    checks++;
    if (!ok || value_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_capture: ok %0d ready %b expected 1 0", ok, value_ready);
    end
    wait_latch(ok);
    checks++;
    if (com_lat !== 8'hFB || seg_lat !== 8'hFF || value_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_old_frame: com %h seg %h ready %b expected FB FF 1",
               com_lat, seg_lat, value_ready);
    end
    wait_latch(ok);
    checks++;
    if (com_lat !== 8'hF7 || seg_lat !== 8'h1F) begin
      fails++;
      $display("FAIL mid_new_frame: com %h seg %h expected F7 1F", com_lat, seg_lat);
    end
    tick_div = 1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lc;
    wait_latch(ok);
    wait_bits(2, ok);
    do_capture(20'd777777, ok);
    wait_bits(4, ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      if (srclk) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || value_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_setup: ok %0d ready %b expected 1 0", ok, value_ready);
    end
    lc = latch_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_vec() !== RST_VEC) begin
      fails++;
      $display("FAIL rstmid_async: got %b expected %b", out_vec(), RST_VEC);
    end
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (out_vec() !== RST_VEC || latch_cnt != lc) begin
      fails++;
      $display("FAIL rstmid_hold: got %b latches %0d expected %b 0",
               out_vec(), latch_cnt - lc, RST_VEC);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (latch_cnt != lc + 1 || seg_lat !== 8'h03 || com_lat !== 8'hFE
        || value_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_after: latches %0d seg %h com %h ready %b expected 1 03 FE 1",
               latch_cnt - lc, seg_lat, com_lat, value_ready);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_capture_123456();
    test_clamp();
    test_lead_blank();
    test_mid_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
